// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI frame receiver: frame layout, bit
// counter sizing and the receive FSM state encoding.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int RW_BIT     = 15;
  localparam int CNT_W      = 5;

  // A complete frame has exactly 16 SCLK edges; 17 marks "too many" and the
  // counter parks there so any overrun length is rejected the same way.
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

  typedef enum logic {
    SPI_IDLE  = 1'b0,
    SPI_SHIFT = 1'b1
  } spi_state_e;

  // R/W flag of a received frame: 1 = write.
  function automatic logic frame_is_write(input logic [FRAME_BITS-1:0] frame);
    return frame[RW_BIT];
  endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// N-stage flop synchronizer for a single asynchronous input.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset, loads RST_VAL into every stage
//   d       : raw asynchronous input
//   q       : synchronized output (STAGES clk cycles of latency)
// Parameters: STAGES (2..3), RST_VAL (value held by the chain in reset).
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {STAGES{RST_VAL}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// -----------------------------------------------------------------------------
// spi_frame_rx
// SPI mode-0 slave receiver. Synchronizes SCLK/MOSI/CS into the clk domain,
// deserializes 16-bit MSB-first frames {R/W, addr[6:0], data[7:0]} and issues
// one register-write strobe per valid write frame. Frames whose SCLK edge
// count is not exactly 16 are rejected with a frame_err pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   spi_sclk   : raw SPI clock
//   spi_mosi   : raw serial data
//   spi_cs     : raw chip select, active-low
//   wr_valid   : one-cycle write strobe
//   wr_addr    : register address, held until the next wr_valid
//   wr_data    : register data, held until the next wr_valid
//   frame_err  : one-cycle pulse for a bit-count violation
//   busy       : high while a frame is being shifted in
//   err_count  : saturating frame_err count (only with SPI_ERR_COUNT_EN)
// Optional feature macro: SPI_ERR_COUNT_EN.
// Latency: raw CS rise -> wr_valid/frame_err is SYNC_STAGES + 2 clk cycles.
// -----------------------------------------------------------------------------
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic              busy
`ifdef SPI_ERR_COUNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam logic [1:0] FLUSH_DONE = 2'(SYNC_STAGES);

  logic sclk_s, mosi_s, cs_s;
  logic sclk_hist_r, mosi_hist_r, cs_hist_r;
  logic sclk_rise_r, cs_fall_r, cs_rise_r;
  logic [1:0] flush_r;
  logic armed_r;

  spi_state_e state_r, next_state_s;
  logic start_s, shift_s, eval_s, frame_ok_s;

  logic [FRAME_BITS-1:0] shift_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  wr_pend_r, err_pend_r;
  logic [FRAME_BITS-1:0] pend_frame_r;

  logic              wr_valid_r, frame_err_r, busy_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs), .q(cs_s)
  );

  // History flops plus registered edge pulses. mosi_hist_r is captured in the
  // same cycle as sclk_rise_r, so it holds the data bit of that SCLK sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_hist_r <= 1'b0;
      mosi_hist_r <= 1'b0;
      cs_hist_r   <= 1'b1;
      sclk_rise_r <= 1'b0;
      cs_fall_r   <= 1'b0;
      cs_rise_r   <= 1'b0;
    end else begin
      sclk_hist_r <= sclk_s;
      mosi_hist_r <= mosi_s;
      cs_hist_r   <= cs_s;
      sclk_rise_r <= sclk_s & ~sclk_hist_r;
      cs_fall_r   <= ~cs_s & cs_hist_r;
      cs_rise_r   <= cs_s & ~cs_hist_r;
    end
  end

  // Arming: the CS chain resets to "high", so a CS that was already low at
  // reset release would look like a falling edge. Frames are only accepted
  // once the chain has flushed and the pin has genuinely been seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_r <= 2'd0;
      armed_r <= 1'b0;
    end else begin
      if (flush_r != FLUSH_DONE) begin
        flush_r <= flush_r + 2'd1;
      end
      if ((flush_r == FLUSH_DONE) && cs_s && cs_hist_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SPI_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state and control decode. A CS rise takes priority over an SCLK
  // edge seen in the same cycle, so that edge is never counted.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    shift_s      = 1'b0;
    eval_s       = 1'b0;
    case (state_r)
      SPI_IDLE: begin
        if (cs_fall_r && armed_r) begin
          next_state_s = SPI_SHIFT;
          start_s      = 1'b1;
        end else begin
          next_state_s = SPI_IDLE;
        end
      end
      SPI_SHIFT: begin
        if (cs_rise_r) begin
          next_state_s = SPI_IDLE;
          eval_s       = 1'b1;
        end else if (sclk_rise_r) begin
          shift_s = 1'b1;
        end else begin
          shift_s = 1'b0;
        end
      end
      default: begin
        next_state_s = SPI_IDLE;
      end
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {FRAME_BITS{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (start_s) begin
      shift_r <= {FRAME_BITS{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (shift_s) begin
      shift_r <= {shift_r[FRAME_BITS-2:0], mosi_hist_r};
      if (cnt_r != CNT_SAT) begin
        cnt_r <= cnt_r + 5'd1;
      end
    end
  end

  assign frame_ok_s = (cnt_r == CNT_FULL);

  // Frame verdict captured at the CS-rise evaluation; outputs follow a cycle
  // later from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_r    <= 1'b0;
      err_pend_r   <= 1'b0;
      pend_frame_r <= {FRAME_BITS{1'b0}};
    end else begin
      wr_pend_r  <= eval_s & frame_ok_s & frame_is_write(shift_r);
      err_pend_r <= eval_s & ~frame_ok_s;
      if (eval_s) begin
        pend_frame_r <= shift_r;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
      wr_addr_r   <= 7'h00;
      wr_data_r   <= 8'h00;
    end else begin
      wr_valid_r  <= wr_pend_r;
      frame_err_r <= err_pend_r;
      busy_r      <= (next_state_s == SPI_SHIFT);
      if (wr_pend_r) begin
        wr_addr_r <= pend_frame_r[RW_BIT-1 -: ADDR_W];
        wr_data_r <= pend_frame_r[DATA_W-1:0];
      end
    end
  end

  assign wr_valid  = wr_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;

`ifdef SPI_ERR_COUNT_EN
  logic [7:0] err_count_r;

  // Saturating count of rejected frames, advanced with the frame_err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= 8'h00;
    end else if (err_pend_r && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'h01;
    end
  end

  assign err_count = err_count_r;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_rx
// Directed bench for spi_frame_rx with a scoreboard: the driver pushes the
// expected strobe (kind, addr, data, due cycle) when it raises CS, and an
// independent monitor pops and compares whenever wr_valid or frame_err fires.
// -----------------------------------------------------------------------------
module tb_spi_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sclk, spi_mosi, spi_cs;
  logic       wr_valid, frame_err, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
`ifdef SPI_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  spi_frame_rx #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_cs   (spi_cs),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_err(frame_err),
    .busy     (busy)
`ifdef SPI_ERR_COUNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  typedef struct {
    logic       is_err;
    logic [6:0] addr;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  localparam int K_WRITE = 0;
  localparam int K_ERR   = 1;
  localparam int K_NONE  = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && (wr_valid === 1'b1 || frame_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, wr_valid, frame_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {30'd0, wr_valid, frame_err},
              mon_e.is_err ? 32'd1 : 32'd2);
        check("strobe_latency", cyc, mon_e.due);
        check("strobe_addr", {25'd0, wr_addr}, {25'd0, mon_e.addr});
        check("strobe_data", {24'd0, wr_data}, {24'd0, mon_e.data});
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Lower CS; busy must still be low 3 cycles later and high at 4.
  task automatic start_cs(input logic busy_exp);
    int c;
    @(negedge clk);
    spi_cs = 1'b0;
    c = cyc;
    wait_neg(3);
    check("busy_before_rise", {31'd0, busy}, 32'd0);
    wait_neg(1);
    check("busy_after_cs_fall", {31'd0, busy}, {31'd0, busy_exp});
  endtask

  // Clock out n bits MSB first, SCLK = clk/8, data changed while SCLK low.
  task automatic shift_bits(input logic [16:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      wait_neg(4);
      spi_sclk = 1'b1;
      wait_neg(4);
      spi_sclk = 1'b0;
    end
  endtask

  // Raise CS, register the expectation, then hold CS high for gap cycles.
  task automatic end_cs(input int kind, input logic [6:0] addr,
                        input logic [7:0] data, input int gap);
    exp_t e;
    wait_neg(4);
    spi_cs = 1'b1;
    if (kind != K_NONE) begin
      e.is_err = (kind == K_ERR);
      e.addr   = addr;
      e.data   = data;
      e.due    = cyc + 5;
      exp_q.push_back(e);
    end
    wait_neg(gap - 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    wait_neg(3);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_addr", {25'd0, wr_addr}, 32'h00);
    check("rst_wr_data", {24'd0, wr_data}, 32'h00);
    rst_n = 1'b1;
    wait_neg(10);

    // Valid write 0x8155.
    start_cs(1'b1);
    shift_bits(17'h08155, 16);
    end_cs(K_WRITE, 7'h01, 8'h55, 12);

    // Read 0x0155: silently dropped, outputs hold.
    start_cs(1'b1);
    shift_bits(17'h00155, 16);
    end_cs(K_NONE, 7'h00, 8'h00, 12);
    check("read_hold_addr", {25'd0, wr_addr}, 32'h01);
    check("read_hold_data", {24'd0, wr_data}, 32'h55);

    // 15-bit and 17-bit frames rejected, then 0x8433 write.
    start_cs(1'b1);
    shift_bits(17'h01234, 15);
    end_cs(K_ERR, 7'h01, 8'h55, 12);
    start_cs(1'b1);
    shift_bits(17'h18433, 17);
    end_cs(K_ERR, 7'h01, 8'h55, 12);
    start_cs(1'b1);
    shift_bits(17'h08433, 16);
    end_cs(K_WRITE, 7'h04, 8'h33, 12);

    // Reset after 8 bits with CS low; finishing the frame must not strobe.
    start_cs(1'b1);
    shift_bits(17'h000AB, 8);
    @(negedge clk);
    rst_n = 1'b0;
    wait_neg(2);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_addr", {25'd0, wr_addr}, 32'h00);
    check("midrst_data", {24'd0, wr_data}, 32'h00);
    rst_n = 1'b1;
    shift_bits(17'h000CD, 8);
    check("midrst_no_frame_busy", {31'd0, busy}, 32'd0);
    end_cs(K_NONE, 7'h00, 8'h00, 12);
    check("midrst_hold_addr", {25'd0, wr_addr}, 32'h00);

    start_cs(1'b1);
    shift_bits(17'h082FF, 16);
    end_cs(K_WRITE, 7'h02, 8'hFF, 12);

    // Zero-bit frame: CS pulse without SCLK.
    start_cs(1'b1);
    end_cs(K_ERR, 7'h02, 8'hFF, 12);

    // Back-to-back with minimum CS-high gap (3 cycles).
    start_cs(1'b1);
    shift_bits(17'h08001, 16);
    end_cs(K_WRITE, 7'h00, 8'h01, 3);
    start_cs(1'b1);
    shift_bits(17'h08080, 16);
    end_cs(K_WRITE, 7'h00, 8'h80, 12);
    check("final_busy", {31'd0, busy}, 32'd0);

`ifdef SPI_ERR_COUNT_EN
    check("err_count_3", {24'd0, err_count}, 32'd3);
    for (int f = 0; f < 260; f++) begin
      start_cs(1'b1);
      shift_bits(17'h00001, 1);
      end_cs(K_ERR, 7'h00, 8'h80, 6);
    end
    wait_neg(10);
    check("err_count_sat", {24'd0, err_count}, 32'hFF);
    wait_neg(10);
    check("err_count_hold", {24'd0, err_count}, 32'hFF);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

SPI-slave front end for the onboarding chip: synchronizes the raw SCLK/MOSI/CS pins into the system clock domain, deserializes 16-bit mode-0 frames, and emits one register-write strobe per valid write frame. Sits between the `ui_in[2:0]` pins and the register bank that drives the PWM peripheral's enable and duty-cycle registers. Malformed frames are rejected and flagged.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops per input, before the edge-detect flop. Legal values are 2–3.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `spi_sclk`, in, 1: raw SPI clock, asynchronous to `clk`.
- `spi_mosi`, in, 1: raw serial data, asynchronous.
- `spi_cs`, in, 1: raw chip select, active-low, asynchronous.
- `wr_valid`, out, 1: one-cycle write strobe.
- `wr_addr`, out, 7: register address. Held until the next `wr_valid`.
- `wr_data`, out, 8: register data. Held until the next `wr_valid`.
- `frame_err`, out, 1: one-cycle pulse when a frame is rejected for bit count.
- `busy`, out, 1: high while a frame is in progress (state SHIFT).

## Operation
- **Frame format:** 16 bits, MSB first, sampled on synchronized SCLK rising edge (mode 0).
  - Bit 15: R/W (1 = write).
  - Bits 14:8: address.
  - Bits 7:0: data.
- **Synchronizers:** each input gets `SYNC_STAGES` flops plus one history flop for edge detection.
  - Reset values: CS = 1, SCLK = 0, MOSI = 0.
- **FSM states:** IDLE, SHIFT.
  - IDLE → SHIFT on synchronized CS falling edge. Clears the 16-bit shift register and the 5-bit bit counter.
  - In SHIFT, each SCLK rising edge shifts MOSI into the LSB. The counter increments and saturates at 17.
  - SHIFT → IDLE on synchronized CS rising edge, with frame evaluation in the same cycle:
    - Count == 16 and R/W = 1: register address/data; `wr_valid` = 1 the next cycle.
    - Count == 16 and R/W = 0: drop silently. Reads are not supported; no error.
    - Count != 16, including 0 and saturated overflow: `frame_err` = 1 the next cycle; `wr_addr`/`wr_data` unchanged.
- **Simultaneous SCLK rise and CS rise in the same sample:** CS wins, and the SCLK edge is not counted.
- **Reset mid-frame:** all state is cleared and the FSM goes to IDLE.
  - If reset releases with CS already low, no frame starts.
  - The block waits for CS to go high, then low again.
- **Reset values:** `wr_valid`, `frame_err` and `busy` = 0; `wr_addr` = 7'h00; `wr_data` = 8'h00.

## Timing
- **Input constraint:** SCLK high and low phases each ≥ `SYNC_STAGES` + 1 `clk` periods. CS high between frames ≥ the same.
- **Write latency:** `wr_valid` asserts `SYNC_STAGES` + 2 `clk` cycles after the first `clk` edge that samples raw CS high. With default 2: 4 cycles.
  - `wr_addr`/`wr_data` are valid in the same cycle as `wr_valid`.
- **`frame_err`:** same latency as `wr_valid`. `wr_valid` and `frame_err` are never high together.
- **`busy`:** rises `SYNC_STAGES` + 1 cycles after raw CS falls; falls in the cycle after the CS-rise evaluation.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`SPI_ERR_COUNT_EN` defined:** adds output `err_count`, out, 8.
  - Saturating count of `frame_err` pulses; holds at 8'hFF.
  - Reset to 0 by `rst_n` only.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Structure
- **Package `spi_pkg`:**
  - `FRAME_BITS` = 16, `ADDR_W` = 7, `DATA_W` = 8, `RW_BIT` = 15.
  - FSM state enum: `SPI_IDLE`, `SPI_SHIFT`.
- **Sub-module `sync_ff`:** parameterized N-stage synchronizer with a reset-value parameter, instantiated three times (SCLK, MOSI, CS).
- Edge detection, shift register, counter and FSM stay in `spi_frame_rx`.

## Test plan
- **Valid write:** frame 0x8155 (write, addr 0x01, data 0x55), SCLK = clk/8 → one `wr_valid` 4 cycles after CS rise; `wr_addr` = 0x01, `wr_data` = 0x55; `frame_err` stays 0.
- **Read frame:** frame 0x0155 → no `wr_valid`, no `frame_err`; outputs keep their previous values.
- **Short and long frames:** 15-bit and 17-bit frames each → one `frame_err` pulse, no `wr_valid`; a following 0x8433 frame writes addr 0x04, data 0x33.
- **Reset mid-frame:** assert `rst_n` low after 8 bits while CS is low, release, finish the clocks, raise CS → no strobe. The next full frame 0x82FF writes addr 0x02, data 0xFF.
- **Back-to-back frames:** 0x8001 then 0x8080 with minimum CS-high gap → two `wr_valid` pulses with data 0x01 then 0x80; `busy` drops between them.
- **Error counter:** with `SPI_ERR_COUNT_EN` defined, 260 short frames → `err_count` = 0xFF and held; undefined → port absent, build clean.
